logic_unit_pipe: RTL and testbench

// - Parametrised, pipelined successor to the basic two-input gate set: applies one of seven

---
 rtl/logic_unit_pkg.sv | 15 +
 rtl/logic_unit_core.sv | 29 ++
 rtl/logic_unit_pipe.sv | 86 ++++++++
 tb/tb_logic_unit_pipe.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pkg.sv
// rtl/logic_unit_pkg.sv - op encodings shared by the logic unit pipeline and its core
package logic_unit_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND  = 3'd0;
  localparam logic [OP_W-1:0] OP_OR   = 3'd1;
  localparam logic [OP_W-1:0] OP_NOT  = 3'd2;
  localparam logic [OP_W-1:0] OP_NAND = 3'd3;
  localparam logic [OP_W-1:0] OP_NOR  = 3'd4;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd5;
  localparam logic [OP_W-1:0] OP_XNOR = 3'd6;
  localparam logic [OP_W-1:0] OP_RSVD = 3'd7;

endpackage

// File: rtl/logic_unit_core.sv
// rtl/logic_unit_core.sv - combinational bitwise gate function, flags the reserved op
module logic_unit_core
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic [WIDTH-1:0] y,
  output logic             err
);

  always_comb begin
    y   = '0;
    err = 1'b0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NOT:  y = ~a;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// rtl/logic_unit_pipe.sv - two-stage valid/ready pipeline around logic_unit_core
// Optional out_parity port enabled by defining LOGIC_PARITY_EN.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [OP_W-1:0]  in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_err
`ifdef LOGIC_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [OP_W-1:0]  s1_op;
  logic [WIDTH-1:0] core_y;
  logic             core_err;
  logic             s1_adv;
  logic             s2_adv;

  // Each stage may load when its own slot is empty or is being drained this cycle.
  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  logic_unit_core #(.WIDTH(WIDTH)) u_core (
    .a   (s1_a),
    .b   (s1_b),
    .op  (s1_op),
    .y   (core_y),
    .err (core_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_op     <= '0;
      out_valid <= 1'b0;
      out_y     <= '0;
      out_err   <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_a  <= in_a;
          s1_b  <= in_b;
          s1_op <= in_op;
        end
      end
      // Output data only moves with a real beat so out_y keeps the last valid result.
      if (s2_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_y   <= core_y;
          out_err <= core_err;
        end
      end
    end
  end

`ifdef LOGIC_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_parity <= 1'b0;
    end else if (s2_adv && s1_valid) begin
      out_parity <= ^core_y;
    end
  end
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb/tb_logic_unit_pipe.sv - randomized self-checking bench for logic_unit_pipe
// Honours LOGIC_PARITY_EN to connect and check out_parity.
module tb_logic_unit_pipe;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] y;
    logic         err;
    int           acc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic [2:0]   in_op = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_y;
  logic         out_err;
`ifdef LOGIC_PARITY_EN
  logic         out_parity;
`endif

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  int   out_cyc[$];
  bit   lat_chk = 1'b0;
  bit   prev_stall = 1'b0;
  logic [W-1:0] prev_y;
  logic         prev_err;

  logic_unit_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_err   (out_err)
`ifdef LOGIC_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [2:0] op, input int c);
    exp_t e;
    e.err = 1'b0;
    e.acc = c;
    case (op)
      3'd0: e.y = a & b;
      3'd1: e.y = a | b;
      3'd2: e.y = ~a;
      3'd3: e.y = ~(a & b);
      3'd4: e.y = ~(a | b);
      3'd5: e.y = a ^ b;
      3'd6: e.y = ~(a ^ b);
      default: begin
        e.y   = '0;
        e.err = 1'b1;
      end
    endcase
    return e;
  endfunction

  // Monitor: all handshakes are judged at the falling edge, ahead of the rising edge that commits them.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", {31'd0, out_valid}, 32'd1);
        check("hold_y", {24'd0, out_y}, {24'd0, prev_y});
        check("hold_err", {31'd0, out_err}, {31'd0, prev_err});
      end
      if (out_valid && !prev_stall && lat_chk && exp_q.size() > 0)
        check("latency", cyc - exp_q[0].acc, 32'd2);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_y", {24'd0, out_y}, {24'd0, e.y});
          check("out_err", {31'd0, out_err}, {31'd0, e.err});
`ifdef LOGIC_PARITY_EN
          check("parity", {31'd0, out_parity}, {31'd0, ^e.y});
`endif
          out_cyc.push_back(cyc);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_y     = out_y;
      prev_err   = out_err;
      if (in_valid && in_ready) exp_q.push_back(model(in_a, in_b, in_op, cyc));
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    bit ok;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_op = op;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("accept_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) break;
    end
    check("drain", exp_q.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n0;
    bit acc_flag;
    logic [7:0] tt_a;
    logic [7:0] tt_b;

    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_y", {24'd0, out_y}, 32'd0);
    check("rst_out_err", {31'd0, out_err}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Truth table with one idle cycle between beats so latency is visible per beat.
    tt_a = 8'hF0;
    tt_b = 8'hCC;
    lat_chk = 1'b1;
    for (int op = 0; op < 8; op++) begin
      send(tt_a, tt_b, 3'(op));
      in_valid = 1'b0;
      wait_idle();
    end
    send(8'hFF, 8'hFF, 3'd7);
    in_valid = 1'b0;
    wait_idle();

    // Streaming: 16 back-to-back beats, results expected on 16 consecutive cycles.
    n0 = out_cyc.size();
    for (int i = 0; i < 16; i++) send(W'($urandom), W'($urandom), 3'($urandom_range(0, 7)));
    in_valid = 1'b0;
    wait_idle();
    check("stream_count", out_cyc.size() - n0, 32'd16);
    if (out_cyc.size() >= n0 + 16)
      check("stream_bubbles", out_cyc[n0+15] - out_cyc[n0], 32'd15);
    lat_chk = 1'b0;

    // Backpressure: two beats fill the pipe, the third must be refused.
    n0 = out_cyc.size();
    out_ready = 1'b0;
    send(8'h5A, 8'h0F, 3'd5);
    send(8'h33, 8'h55, 3'd0);
    in_valid = 1'b1;
    in_a = 8'h81;
    in_b = 8'h18;
    in_op = 3'd4;
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(8'h81, 8'h18, 3'd4);
    in_valid = 1'b0;
    wait_idle();
    check("bp_count", out_cyc.size() - n0, 32'd3);

    // Reset with beats in flight: everything discarded, async clear.
    out_ready = 1'b0;
    send(8'h11, 8'h22, 3'd1);
    send(8'h44, 8'h88, 3'd1);
    in_valid = 1'b1;
    #1 rst = 1'b1;
    exp_q.delete();
    #1;
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_out_y", {24'd0, out_y}, 32'd0);
    check("arst_out_err", {31'd0, out_err}, 32'd0);
    check("arst_in_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("no_stale", {31'd0, out_valid}, 32'd0);
    end
    @(posedge clk);
    #1;
    send(8'hA5, 8'h0F, 3'd6);
    in_valid = 1'b0;
    wait_idle();

    // Randomized traffic with random backpressure; the monitor compares every beat.
    acc_flag = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      acc_flag = in_valid && in_ready;
      @(posedge clk);
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid || acc_flag) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_a = W'($urandom);
        in_b = W'($urandom);
        in_op = 3'($urandom_range(0, 7));
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_idle();
    check("final_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
